// File: rtl/leb128_encoder_if.sv
// Value-in / byte-out stream bundle for the LEB128 encoder.
// slave is the encoder's view; master is the producer/sink side that drives it.
interface leb128_encoder_if;
  logic [63:0] in_data;
  logic        in_signed;
  logic        in_is32;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [3:0]  out_index;

  modport slave (
    input  in_data, in_signed, in_is32, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_last, out_index
  );

  modport master (
    output in_data, in_signed, in_is32, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_last, out_index
  );
endinterface

// File: rtl/leb128_encoder.sv
// Streaming SLEB128/ULEB128 encoder: one 32/64-bit value in, 1..10 bytes out.
// A 64-bit shift register supplies 7 bits per byte until the remainder is pure sign/zero fill.
module leb128_encoder (
  input  logic             clk,
  input  logic             reset,
  leb128_encoder_if.slave  bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] v_q, v_d;
  logic        signed_q, signed_d;
  logic [3:0]  index_q, index_d;
  logic [56:0] upper;
  logic        done;
  logic        emit;

  // The sequence ends once the bits above the current 7-bit group carry no information.
  always_comb begin
    upper = v_q[63:7];
    if (signed_q) begin
      done = ((upper == '0) && !v_q[6]) || ((&upper) && v_q[6]);
    end else begin
      done = (upper == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    signed_d = signed_q;
    index_d  = index_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          v_d      = bus.in_is32
                     ? {{32{bus.in_signed & bus.in_data[31]}}, bus.in_data[31:0]}
                     : bus.in_data;
          signed_d = bus.in_signed;
          index_d  = 4'd0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (done) begin
            state_d = IDLE;
          end else begin
            v_d     = {(signed_q ? {7{v_q[63]}} : 7'd0), v_q[63:7]};
            index_d = index_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      v_q      <= '0;
      signed_q <= 1'b0;
      index_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      signed_q <= signed_d;
      index_q  <= index_d;
    end
  end

  // Byte outputs are forced to zero outside EMIT so stale shift-register bits never leak.
  assign emit          = (state_q == EMIT);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = emit;
  assign bus.out_last  = emit & done;
  assign bus.out_byte  = emit ? {~done, v_q[6:0]} : 8'h00;
  assign bus.out_index = emit ? index_q : 4'd0;

endmodule

// File: tb/tb_leb128_encoder.sv
// Scoreboard bench for leb128_encoder: expected bytes are queued at send time and
// compared as the encoder hands each byte over.
module tb_leb128_encoder;

  typedef struct {
    logic [7:0] b;
    logic       last;
    logic [3:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  leb128_encoder_if bus ();

  leb128_encoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Queue an n-byte reference sequence; byte i lives in bytes[8*i +: 8].
  task automatic push_seq(input int n, input logic [79:0] bytes);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.b    = bytes[8*i +: 8];
      e.last = (i == n - 1);
      e.idx  = 4'(i);
      sb.push_back(e);
    end
  endtask

  // Reference encoder written in the classic software form.
  task automatic model_push(input logic [63:0] d, input logic s, input logic w);
    longint      sv;
    logic [63:0] uv;
    logic [7:0]  b;
    logic        more;
    exp_t        e;
    int          i;
    if (w && s)  sv = longint'(int'(d[31:0]));
    else if (w)  sv = longint'({32'd0, d[31:0]});
    else         sv = longint'(d);
    uv   = 64'(sv);
    i    = 0;
    more = 1'b1;
    while (more) begin
      b = {1'b0, uv[6:0]};
      if (s) begin
        sv   = sv >>> 7;
        uv   = 64'(sv);
        more = !(((sv == 0) && !b[6]) || ((sv == -1) && b[6]));
      end else begin
        uv   = uv >> 7;
        more = (uv != 0);
      end
      e.b    = more ? (b | 8'h80) : b;
      e.last = !more;
      e.idx  = 4'(i);
      sb.push_back(e);
      i++;
    end
  endtask

  // Offer one value at a negedge; returns at the negedge after it was taken.
  task automatic send(input logic [63:0] d, input logic s, input logic w, output logic tmo);
    bus.in_data   = d;
    bus.in_signed = s;
    bus.in_is32   = w;
    bus.in_valid  = 1'b1;
    tmo = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (bus.in_ready === 1'b1) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_data   = {$urandom, $urandom};
    bus.in_signed = 1'($urandom_range(1));
    bus.in_is32   = 1'($urandom_range(1));
  endtask

  // Wait for the next byte transfer with random sink readiness; reports what was seen.
  task automatic grab(input int pct, output logic [7:0] b, output logic last,
                      output logic [3:0] idx, output logic stable,
                      output logic rdy_seen, output logic tmo);
    logic seen;
    seen = 1'b0; stable = 1'b1; rdy_seen = 1'b0; tmo = 1'b1;
    b = 8'h00; last = 1'b0; idx = 4'd0;
    for (int c = 0; c < 300; c++) begin
      bus.out_ready = ($urandom_range(99) < pct);
      if (bus.out_valid === 1'b1) begin
        if (bus.in_ready !== 1'b0) rdy_seen = 1'b1;
        if (!seen) begin
          b = bus.out_byte; last = bus.out_last; idx = bus.out_index; seen = 1'b1;
        end else if (bus.out_byte !== b || bus.out_last !== last || bus.out_index !== idx) begin
          stable = 1'b0;
        end
        if (bus.out_ready) begin
          tmo = 1'b0;
          @(posedge clk);
          @(negedge clk);
          bus.out_ready = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_data = '0; bus.in_signed = 1'b0; bus.in_is32 = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.out_index !== 4'd0) begin errors++; $display("[TB] FAIL reset out_index: got %0d want 0", bus.out_index); end
    checks++; if (bus.out_byte !== 8'h00) begin errors++; $display("[TB] FAIL reset out_byte: got %h want 00", bus.out_byte); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 1", bus.in_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [63:0] d[2]; int n[2]; logic [79:0] q[2];
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    d = '{64'd624485, 64'd0};
    n = '{3, 1};
    q = '{{8'h26, 8'h8E, 8'hE5}, 80'h00};
    for (int k = 0; k < 2; k++) begin
      push_seq(n[k], q[k]);
      send(d[k], 1'b0, 1'b0, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL unsigned accept: in_ready never rose"); end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        grab(100, b, last, idx, st, rdy, tmo);
        checks++; if (tmo) begin errors++; $display("[TB] FAIL unsigned timeout: byte %0d never arrived", e.idx); sb.delete(); break; end
        checks++; if (b !== e.b) begin errors++; $display("[TB] FAIL unsigned byte: got %h want %h", b, e.b); end
        checks++; if (last !== e.last) begin errors++; $display("[TB] FAIL unsigned last: got %b want %b", last, e.last); end
        checks++; if (idx !== e.idx) begin errors++; $display("[TB] FAIL unsigned index: got %0d want %0d", idx, e.idx); end
      end
    end
  endtask

  task automatic test_signed();
    logic [63:0] d[4]; int n[4]; logic [79:0] q[4];
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    d = '{-64'sd123456, -64'sd1, 64'd64, -64'sd65};
    n = '{3, 1, 2, 2};
    q = '{{8'h78, 8'hBB, 8'hC0}, 80'h7F, {8'h00, 8'hC0}, {8'h7F, 8'hBF}};
    for (int k = 0; k < 4; k++) begin
      push_seq(n[k], q[k]);
      send(d[k], 1'b1, 1'b0, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL signed accept: in_ready never rose"); end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        grab(100, b, last, idx, st, rdy, tmo);
        checks++; if (tmo) begin errors++; $display("[TB] FAIL signed timeout: byte %0d never arrived", e.idx); sb.delete(); break; end
        checks++; if (b !== e.b) begin errors++; $display("[TB] FAIL signed byte: got %h want %h", b, e.b); end
        checks++; if (last !== e.last) begin errors++; $display("[TB] FAIL signed last: got %b want %b", last, e.last); end
        checks++; if (idx !== e.idx) begin errors++; $display("[TB] FAIL signed index: got %0d want %0d", idx, e.idx); end
      end
    end
  endtask

  task automatic test_width();
    logic [63:0] d[3]; logic s[3]; logic w[3]; int n[3]; logic [79:0] q[3];
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    d = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_FFFF_FFFF};
    s = '{1'b0, 1'b1, 1'b0};
    w = '{1'b0, 1'b1, 1'b1};
    n = '{10, 5, 5};
    q = '{{8'h01, {9{8'hFF}}}, {8'h78, 8'h80, 8'h80, 8'h80, 8'h80},
          {8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    for (int k = 0; k < 3; k++) begin
      push_seq(n[k], q[k]);
      send(d[k], s[k], w[k], tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL width accept: in_ready never rose"); end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        grab(100, b, last, idx, st, rdy, tmo);
        checks++; if (tmo) begin errors++; $display("[TB] FAIL width timeout: byte %0d never arrived", e.idx); sb.delete(); break; end
        checks++; if (b !== e.b) begin errors++; $display("[TB] FAIL width byte: got %h want %h", b, e.b); end
        checks++; if (last !== e.last) begin errors++; $display("[TB] FAIL width last: got %b want %b", last, e.last); end
        checks++; if (idx !== e.idx) begin errors++; $display("[TB] FAIL width index: got %0d want %0d", idx, e.idx); end
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] d; logic s, w;
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom} >> $urandom_range(63);
      s = 1'($urandom_range(1));
      w = 1'($urandom_range(1));
      model_push(d, s, w);
      send(d, s, w, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL random accept: in_ready never rose"); end
      while (sb.size() > 0) begin
        e = sb.pop_front();
        grab(70, b, last, idx, st, rdy, tmo);
        checks++; if (tmo) begin errors++; $display("[TB] FAIL random timeout: byte %0d never arrived", e.idx); sb.delete(); break; end
        checks++; if (b !== e.b) begin errors++; $display("[TB] FAIL random byte: d=%h s=%b w=%b got %h want %h", d, s, w, b, e.b); end
        checks++; if (last !== e.last) begin errors++; $display("[TB] FAIL random last: got %b want %b", last, e.last); end
        checks++; if (idx !== e.idx) begin errors++; $display("[TB] FAIL random index: got %0d want %0d", idx, e.idx); end
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    push_seq(3, {8'h26, 8'h8E, 8'hE5});
    send(64'd624485, 1'b0, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL bp accept: in_ready never rose"); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      grab(40, b, last, idx, st, rdy, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL bp timeout: byte %0d never arrived", e.idx); sb.delete(); break; end
      checks++; if (b !== e.b) begin errors++; $display("[TB] FAIL bp byte: got %h want %h", b, e.b); end
      checks++; if (idx !== e.idx) begin errors++; $display("[TB] FAIL bp index: got %0d want %0d", idx, e.idx); end
      checks++; if (st !== 1'b1) begin errors++; $display("[TB] FAIL bp stable: got %b want 1", st); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp in_ready during emit: got %b want 0", rdy); end
    end
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL bp idle: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL midreset accept: in_ready never rose"); end
    for (int i = 0; i < 3; i++) begin
      grab(100, b, last, idx, st, rdy, tmo);
      checks++; if (b !== 8'hFF || idx !== 4'(i) || tmo) begin
        errors++; $display("[TB] FAIL midreset prefix: got %h idx %0d want ff idx %0d", b, idx, i);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset aborted: got out_valid=%b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
    push_seq(1, 80'h05);
    send(64'd5, 1'b0, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL midreset reaccept: in_ready never rose"); end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      grab(100, b, last, idx, st, rdy, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL midreset timeout: byte never arrived"); sb.delete(); break; end
      checks++; if (b !== e.b || last !== e.last || idx !== e.idx) begin
        errors++; $display("[TB] FAIL midreset follow-up: got %h/%b/%0d want %h/%b/%0d", b, last, idx, e.b, e.last, e.idx);
      end
    end
  endtask

  task automatic test_input_ignored();
    exp_t e; logic [7:0] b; logic last, st, rdy, tmo; logic [3:0] idx;
    push_seq(3, {8'h26, 8'h8E, 8'hE5});
    send(64'd624485, 1'b0, 1'b0, tmo);
    checks++; if (tmo) begin errors++; $display("[TB] FAIL ignore accept: in_ready never rose"); end
    bus.in_data = 64'd77; bus.in_signed = 1'b0; bus.in_is32 = 1'b0; bus.in_valid = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      grab(100, b, last, idx, st, rdy, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL ignore timeout: byte %0d never arrived", e.idx); sb.delete(); break; end
      checks++; if (b !== e.b || idx !== e.idx) begin errors++; $display("[TB] FAIL ignore byte: got %h idx %0d want %h idx %0d", b, idx, e.b, e.idx); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL ignore in_ready during emit: got %b want 0", rdy); end
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ignore idle in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    push_seq(1, 80'h4D);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      grab(100, b, last, idx, st, rdy, tmo);
      checks++; if (tmo) begin errors++; $display("[TB] FAIL ignore second timeout: byte never arrived"); sb.delete(); break; end
      checks++; if (b !== e.b || last !== e.last || idx !== e.idx) begin
        errors++; $display("[TB] FAIL ignore second value: got %h/%b/%0d want %h/%b/%0d", b, last, idx, e.b, e.last, e.idx);
      end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ignore final idle: got out_valid=%b want 0", bus.out_valid); end
  endtask

  initial begin
    $display("[TB] leb128_encoder bench start");
    test_reset();
    test_unsigned();
    test_signed();
    test_width();
    test_backpressure();
    test_reset_midstream();
    test_input_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
